// File: rtl/n2_dta_param_array.sv
// n2_dta_param_array: set-associative tag/valid array with registered compare
// and a flash-invalidate sweep that also runs after reset.
module n2_dta_param_array #(
    parameter int NUM_WAYS = 4,
    parameter int INDEX_W  = 7,
    parameter int TAG_W    = 30,
    localparam int WAY_W   = $clog2(NUM_WAYS),
    localparam int DEPTH   = 1 << INDEX_W
) (
    input  logic                      l2clk,
    input  logic                      arst_l,
    input  logic [INDEX_W-1:0]        index0_x,
    input  logic [INDEX_W-1:0]        index1_x,
    input  logic                      index_sel_x,
    input  logic [WAY_W-1:0]          wrway_x,
    input  logic                      rdreq_x,
    input  logic                      wrreq_x,
    input  logic [TAG_W-1:0]          wrtag_x,
    input  logic [TAG_W-1:0]          cmptag_x,
    input  logic                      dta_clken,
    input  logic                      wr_inhibit,
    input  logic                      inv_all_req,
    output logic [NUM_WAYS*TAG_W-1:0] rdtag_y,
    output logic [NUM_WAYS-1:0]       rdvld_y,
    output logic [NUM_WAYS-1:0]       rdhit_y,
    output logic                      inv_busy,
    output logic                      acc_err
);
    typedef enum logic {SWEEP, IDLE} state_t;

    state_t               r_state, w_state_nxt;
    logic [INDEX_W-1:0]   r_cnt, w_cnt_nxt;
    logic [TAG_W-1:0]     r_tag [DEPTH][NUM_WAYS];
    logic [NUM_WAYS-1:0]  r_vld [DEPTH];
    logic [INDEX_W-1:0]   w_idx;
    logic                 w_idle, w_wr, w_rd, w_err;

    assign w_idx    = index_sel_x ? index1_x : index0_x;
    assign w_idle   = r_state == IDLE;
    assign w_wr     = w_idle & wrreq_x & dta_clken & ~wr_inhibit;
    assign w_rd     = w_idle & rdreq_x & dta_clken & ~wrreq_x;
    assign w_err    = (rdreq_x | wrreq_x) & (~w_idle | ~dta_clken | (rdreq_x & wrreq_x));
    assign inv_busy = r_state == SWEEP;

    always_ff @(posedge l2clk or negedge arst_l) begin
        if (!arst_l) begin
            r_state <= SWEEP;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Counter parks on the final set; entering a new sweep reloads it.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (r_state == SWEEP) begin
            if (&r_cnt) w_state_nxt = IDLE;
            else        w_cnt_nxt   = r_cnt + 1'b1;
        end else if (inv_all_req) begin
            w_state_nxt = SWEEP;
            w_cnt_nxt   = '0;
        end
    end

    always_ff @(posedge l2clk) begin
        if (r_state == SWEEP) begin
            r_vld[r_cnt] <= '0;
        end else if (w_wr) begin
            r_vld[w_idx][wrway_x] <= 1'b1;
            r_tag[w_idx][wrway_x] <= wrtag_x;
        end
    end

    always_ff @(posedge l2clk or negedge arst_l) begin
        if (!arst_l) begin
            rdtag_y <= '0;
            rdvld_y <= '0;
            rdhit_y <= '0;
            acc_err <= 1'b0;
        end else begin
            acc_err <= w_err;
            if (w_rd) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    rdvld_y[w]                 <= r_vld[w_idx][w];
                    rdtag_y[w*TAG_W +: TAG_W]  <= r_vld[w_idx][w] ? r_tag[w_idx][w] : '0;
                    rdhit_y[w]                 <= r_vld[w_idx][w] && (r_tag[w_idx][w] == cmptag_x);
                end
            end
        end
    end
endmodule

// File: tb/tb_n2_dta_param_array.sv
// tb_n2_dta_param_array: directed checks of the tag array at 4 ways / 7 index bits / 30 tag bits.
module tb_n2_dta_param_array;
    logic         l2clk = 1'b0;
    logic         arst_l;
    logic [6:0]   index0_x, index1_x;
    logic         index_sel_x;
    logic [1:0]   wrway_x;
    logic         rdreq_x, wrreq_x;
    logic [29:0]  wrtag_x, cmptag_x;
    logic         dta_clken, wr_inhibit, inv_all_req;
    logic [119:0] rdtag_y;
    logic [3:0]   rdvld_y, rdhit_y;
    logic         inv_busy, acc_err;

    int tests = 0;
    int fails = 0;
    int n;

    n2_dta_param_array dut (
        .l2clk(l2clk), .arst_l(arst_l), .index0_x(index0_x), .index1_x(index1_x),
        .index_sel_x(index_sel_x), .wrway_x(wrway_x), .rdreq_x(rdreq_x), .wrreq_x(wrreq_x),
        .wrtag_x(wrtag_x), .cmptag_x(cmptag_x), .dta_clken(dta_clken), .wr_inhibit(wr_inhibit),
        .inv_all_req(inv_all_req), .rdtag_y(rdtag_y), .rdvld_y(rdvld_y), .rdhit_y(rdhit_y),
        .inv_busy(inv_busy), .acc_err(acc_err)
    );

    always #5 l2clk = ~l2clk;

    task automatic tick;
        @(posedge l2clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Counts edges until inv_busy drops, bounded so a stuck sweep still ends.
    task automatic count_sweep(input int start, output int cnt);
        cnt = start;
        while (inv_busy && cnt < 400) begin
            tick();
            cnt++;
        end
    endtask

    task automatic wr(input logic [6:0] idx, input logic [1:0] way, input logic [29:0] tag);
        index_sel_x = 1'b1; index1_x = idx; wrway_x = way; wrtag_x = tag; wrreq_x = 1'b1;
        tick();
        wrreq_x = 1'b0;
    endtask

    task automatic rd(input logic [6:0] idx, input logic [29:0] cmp);
        index_sel_x = 1'b0; index0_x = idx; cmptag_x = cmp; rdreq_x = 1'b1;
        tick();
        rdreq_x = 1'b0;
    endtask

    initial begin
        arst_l = 1'b0; index0_x = '0; index1_x = '0; index_sel_x = 1'b0; wrway_x = '0;
        rdreq_x = 1'b0; wrreq_x = 1'b0; wrtag_x = '0; cmptag_x = '0;
        dta_clken = 1'b1; wr_inhibit = 1'b0; inv_all_req = 1'b0;
        #2;
        chk("rst_busy", 128'(inv_busy), 128'd1);
        chk("rst_vld", 128'(rdvld_y), 128'd0);
        chk("rst_err", 128'(acc_err), 128'd0);
        tick(); tick();
        arst_l = 1'b1;
        count_sweep(0, n);
        chk("init_sweep_len", 128'(n), 128'd128);
        rd(7'd5, 30'd0);
        chk("rd5_vld", 128'(rdvld_y), 128'd0);
        chk("rd5_tag", 128'(rdtag_y), 128'd0);
        chk("rd5_err", 128'(acc_err), 128'd0);

        wr(7'd3, 2'd2, 30'h1234567);
        chk("wr3_err", 128'(acc_err), 128'd0);
        rd(7'd3, 30'h1234567);
        chk("rd3_vld", 128'(rdvld_y), 128'h4);
        chk("rd3_hit", 128'(rdhit_y), 128'h4);
        chk("rd3_tag", 128'(rdtag_y), 128'(30'h1234567) << 60);
        tick();
        chk("hold_vld", 128'(rdvld_y), 128'h4);
        rd(7'd3, 30'h1234568);
        chk("miss_hit", 128'(rdhit_y), 128'd0);
        chk("miss_vld", 128'(rdvld_y), 128'h4);

        index_sel_x = 1'b1; index1_x = 7'd9; wrway_x = 2'd0; wrtag_x = 30'hABC;
        rdreq_x = 1'b1; wrreq_x = 1'b1;
        tick();
        rdreq_x = 1'b0; wrreq_x = 1'b0;
        chk("both_err", 128'(acc_err), 128'd1);
        chk("both_vld_hold", 128'(rdvld_y), 128'h4);
        chk("both_tag_hold", 128'(rdtag_y), 128'(30'h1234567) << 60);
        tick();
        chk("both_err_pulse", 128'(acc_err), 128'd0);
        rd(7'd9, 30'hABC);
        chk("rd9_vld", 128'(rdvld_y), 128'h1);
        chk("rd9_hit", 128'(rdhit_y), 128'h1);
        chk("rd9_tag", 128'(rdtag_y), 128'h0ABC);

        wr_inhibit = 1'b1;
        wr(7'd4, 2'd1, 30'h5);
        wr_inhibit = 1'b0;
        chk("inh_err", 128'(acc_err), 128'd0);
        rd(7'd4, 30'h5);
        chk("inh_vld", 128'(rdvld_y), 128'd0);

        dta_clken = 1'b0;
        rd(7'd9, 30'hABC);
        dta_clken = 1'b1;
        chk("noclk_err", 128'(acc_err), 128'd1);
        chk("noclk_vld", 128'(rdvld_y), 128'd0);

        for (int w = 0; w < 4; w++) wr(7'd127, 2'(w), 30'(32'h100 + w));
        rd(7'd127, 30'h102);
        chk("fill_vld", 128'(rdvld_y), 128'hF);
        chk("fill_hit", 128'(rdhit_y), 128'h4);
        inv_all_req = 1'b1;
        tick();
        chk("inv_busy", 128'(inv_busy), 128'd1);
        rdreq_x = 1'b1; index0_x = 7'd127;
        tick();
        rdreq_x = 1'b0; inv_all_req = 1'b0;
        chk("sweep_rd_err", 128'(acc_err), 128'd1);
        chk("sweep_rd_vld", 128'(rdvld_y), 128'hF);
        count_sweep(1, n);
        chk("inv_sweep_len", 128'(n), 128'd128);
        rd(7'd127, 30'h102);
        chk("post_inv_vld", 128'(rdvld_y), 128'd0);
        chk("post_inv_hit", 128'(rdhit_y), 128'd0);

        wr(7'd10, 2'd3, 30'h3FFFFFFF);
        rd(7'd10, 30'h3FFFFFFF);
        chk("rd10_vld", 128'(rdvld_y), 128'h8);
        chk("rd10_tag", 128'(rdtag_y), 128'(30'h3FFFFFFF) << 90);
        inv_all_req = 1'b1;
        tick();
        inv_all_req = 1'b0;
        repeat (60) tick();
        chk("mid_busy", 128'(inv_busy), 128'd1);
        arst_l = 1'b0;
        #1;
        chk("mid_rst_busy", 128'(inv_busy), 128'd1);
        chk("mid_rst_vld", 128'(rdvld_y), 128'd0);
        chk("mid_rst_tag", 128'(rdtag_y), 128'd0);
        tick();
        arst_l = 1'b1;
        count_sweep(0, n);
        chk("mid_rst_sweep_len", 128'(n), 128'd128);
        rd(7'd10, 30'h3FFFFFFF);
        chk("rst_clear_vld", 128'(rdvld_y), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
